// File: rtl/layer00_conv_ctrl.sv
// layer00 3x3 conv sequencer: walks W x H pixels, nine taps each,
// zero-pads borders and emits MAC sideband aligned to buffer data.
module layer00_conv_ctrl #(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1,
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              iStart,
  input  logic              iStall,
  output logic              oBusy,
  output logic              oDone,
  output logic              oRdEn,
  output logic [ADDR_W-1:0] oRdAddr,
  output logic              oMacValid,
  output logic              oMacFirst,
  output logic              oMacLast,
  output logic              oMacPad,
  output logic [3:0]        oMacTap,
  output logic [RW-1:0]     oRow,
  output logic [CW-1:0]     oCol
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       first;
    logic       last;
    logic       pad;
    logic [3:0] tap;
  } sb_t;

  state_t            r_state;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [3:0]        r_tap;
  logic [2:0]        r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_rden;
  logic [ADDR_W-1:0] r_addr;
  sb_t               r_sb;
  sb_t               r_pipe [RD_LAT];

  int   w_ky;
  int   w_kx;
  int   w_yy;
  int   w_xx;
  int   w_lin;
  logic w_inb;
  logic w_end_tap;
  logic w_end_col;
  logic w_end_row;

  // signed int math so a -1 neighbour is caught as out of bounds
  always_comb begin
    w_ky = 0;
    if (r_tap >= 4'd6) begin
      w_ky = 2;
    end else if (r_tap >= 4'd3) begin
      w_ky = 1;
    end
    w_kx  = int'(r_tap) - 3 * w_ky;
    w_yy  = int'(r_row) + w_ky - 1;
    w_xx  = int'(r_col) + w_kx - 1;
    w_inb = (w_yy >= 0) && (w_yy < IMG_H) &&
            (w_xx >= 0) && (w_xx < IMG_W);
    w_lin = w_yy * IMG_W + w_xx;
    w_end_tap = (r_tap == 4'd8);
    w_end_col = (r_col == CW'(IMG_W - 1));
    w_end_row = (r_row == RW'(IMG_H - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_tap   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rden  <= 1'b0;
      r_addr  <= '0;
      r_sb    <= '0;
    end else begin
      r_rden <= 1'b0;
      r_sb   <= '0;
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_row   <= '0;
            r_col   <= '0;
            r_tap   <= '0;
          end
        end
        S_RUN: begin
          if (!iStall) begin
            r_rden <= w_inb;
            r_addr <= w_inb ? ADDR_W'(w_lin) : '0;
            r_sb   <= '{valid: 1'b1,
                        first: (r_tap == 4'd0),
                        last:  w_end_tap,
                        pad:   !w_inb,
                        tap:   r_tap};
            if (!w_end_tap) begin
              r_tap <= r_tap + 4'd1;
            end else begin
              r_tap <= '0;
              if (!w_end_col) begin
                r_col <= r_col + 1'b1;
              end else begin
                r_col <= '0;
                if (!w_end_row) begin
                  r_row <= r_row + 1'b1;
                end else begin
                  r_row   <= '0;
                  r_cnt   <= '0;
                  r_state <= S_DRAIN;
                end
              end
            end
          end
        end
        S_DRAIN: begin
          if (r_cnt == 3'(RD_LAT)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // free-running delay; stalls show up as bubbles, not holds
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= r_sb;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign oBusy     = r_busy;
  assign oDone     = r_done;
  assign oRdEn     = r_rden;
  assign oRdAddr   = r_addr;
  assign oMacValid = r_pipe[RD_LAT-1].valid;
  assign oMacFirst = r_pipe[RD_LAT-1].first;
  assign oMacLast  = r_pipe[RD_LAT-1].last;
  assign oMacPad   = r_pipe[RD_LAT-1].pad;
  assign oMacTap   = r_pipe[RD_LAT-1].tap;
  assign oRow      = r_row;
  assign oCol      = r_col;

endmodule

// File: tb/tb_layer00_conv_ctrl.sv
// Directed bench for layer00_conv_ctrl on a 4x4 map,
// one instance at RD_LAT=1 and one at RD_LAT=3.
module tb_layer00_conv_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic s1 = 1'b0, st1 = 1'b0;
  logic s3 = 1'b0, st3 = 1'b0;

  logic       d1_busy, d1_done, d1_en, d1_mv, d1_mf, d1_ml, d1_mp;
  logic [8:0] d1_ad;
  logic [3:0] d1_mt;
  logic [1:0] d1_row, d1_col;
  logic       d3_busy, d3_done, d3_en, d3_mv, d3_mf, d3_ml, d3_mp;
  logic [8:0] d3_ad;
  logic [3:0] d3_mt;
  logic [1:0] d3_row, d3_col;

  layer00_conv_ctrl #(
    .IMG_W(4), .IMG_H(4), .ADDR_W(9), .RD_LAT(1)
  ) u_d1 (
    .clk(clk), .rstn(rstn), .iStart(s1), .iStall(st1),
    .oBusy(d1_busy), .oDone(d1_done), .oRdEn(d1_en),
    .oRdAddr(d1_ad), .oMacValid(d1_mv), .oMacFirst(d1_mf),
    .oMacLast(d1_ml), .oMacPad(d1_mp), .oMacTap(d1_mt),
    .oRow(d1_row), .oCol(d1_col)
  );

  layer00_conv_ctrl #(
    .IMG_W(4), .IMG_H(4), .ADDR_W(9), .RD_LAT(3)
  ) u_d3 (
    .clk(clk), .rstn(rstn), .iStart(s3), .iStall(st3),
    .oBusy(d3_busy), .oDone(d3_done), .oRdEn(d3_en),
    .oRdAddr(d3_ad), .oMacValid(d3_mv), .oMacFirst(d3_mf),
    .oMacLast(d3_ml), .oMacPad(d3_mp), .oMacTap(d3_mt),
    .oRow(d3_row), .oCol(d3_col)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit sel3;

  logic       en [0:299];
  logic [8:0] ad [0:299];
  logic       mv [0:299];
  logic       mf [0:299];
  logic       ml [0:299];
  logic       mp [0:299];
  logic [3:0] mt [0:299];
  logic       dn [0:299];
  logic       bz [0:299];
  logic [1:0] rw [0:299];
  logic [1:0] cl [0:299];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input int n);
    if (sel3) begin
      en[n] = d3_en; ad[n] = d3_ad; mv[n] = d3_mv;
      mf[n] = d3_mf; ml[n] = d3_ml; mp[n] = d3_mp;
      mt[n] = d3_mt; dn[n] = d3_done; bz[n] = d3_busy;
      rw[n] = d3_row; cl[n] = d3_col;
    end else begin
      en[n] = d1_en; ad[n] = d1_ad; mv[n] = d1_mv;
      mf[n] = d1_mf; ml[n] = d1_ml; mp[n] = d1_mp;
      mt[n] = d1_mt; dn[n] = d1_done; bz[n] = d1_busy;
      rw[n] = d1_row; cl[n] = d1_col;
    end
  endtask

  // index n = cycles after the edge that accepts iStart
  task automatic run(input bit s, input int stall_at,
                     input int stall_len, input int nticks,
                     input int sa1, input int sa2);
    bit p;
    sel3 = s;
    if (s) s3 = 1'b1; else s1 = 1'b1;
    tick();
    rec(0);
    for (int n = 1; n <= nticks; n++) begin
      p = (n - 1 == sa1) || (n - 1 == sa2);
      if (s) s3 = p; else s1 = p;
      st1 = !s && (n - 1 >= stall_at) &&
            (n - 1 < stall_at + stall_len);
      tick();
      rec(n);
    end
    s1 = 1'b0;
    s3 = 1'b0;
    st1 = 1'b0;
  endtask

  function automatic void geo(input int t, output bit e,
                              output int a);
    int pix, tp, r, c, yy, xx;
    pix = t / 9;
    tp = t % 9;
    r = pix / 4;
    c = pix % 4;
    yy = r + tp / 3 - 1;
    xx = c + tp % 3 - 1;
    e = (yy >= 0) && (yy < 4) && (xx >= 0) && (xx < 4);
    a = e ? yy * 4 + xx : 0;
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    checks++;
    if ({d1_busy, d1_done, d1_en, d1_ad, d1_mv, d1_mf, d1_ml,
         d1_mp, d1_mt, d1_row, d1_col} !== '0) begin
      errors++;
      $display("FAIL reset_d1 got busy=%b done=%b en=%b ad=%0d mv=%b",
               d1_busy, d1_done, d1_en, d1_ad, d1_mv);
    end
    checks++;
    if ({d3_busy, d3_done, d3_en, d3_ad, d3_mv, d3_mf, d3_ml,
         d3_mp, d3_mt, d3_row, d3_col} !== '0) begin
      errors++;
      $display("FAIL reset_d3 got busy=%b done=%b en=%b ad=%0d mv=%b",
               d3_busy, d3_done, d3_en, d3_ad, d3_mv);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_full();
    bit e;
    int a, nd, nv, pix;
    nd = 0;
    nv = 0;
    run(0, -1, 0, 160, -1, -1);
    for (int n = 1; n <= 144; n++) begin
      geo(n - 1, e, a);
      checks++;
      if (en[n] !== e || ad[n] !== 9'(a)) begin
        errors++;
        $display("FAIL full_addr n=%0d got en=%b ad=%0d exp en=%b ad=%0d",
                 n, en[n], ad[n], e, a);
      end
    end
    for (int n = 2; n <= 145; n++) begin
      geo(n - 2, e, a);
      checks++;
      if (mv[n] !== 1'b1 || mt[n] !== 4'((n - 2) % 9) ||
          mp[n] !== !e || mf[n] !== ((n - 2) % 9 == 0) ||
          ml[n] !== ((n - 2) % 9 == 8)) begin
        errors++;
        $display("FAIL full_mac n=%0d got v=%b t=%0d p=%b f=%b l=%b",
                 n, mv[n], mt[n], mp[n], mf[n], ml[n]);
      end
    end
    for (int n = 1; n <= 143; n++) begin
      pix = n / 9;
      checks++;
      if (rw[n] !== 2'(pix / 4) || cl[n] !== 2'(pix % 4)) begin
        errors++;
        $display("FAIL full_rowcol n=%0d got %0d,%0d exp %0d,%0d",
                 n, rw[n], cl[n], pix / 4, pix % 4);
      end
    end
    for (int n = 0; n <= 160; n++) begin
      nd += int'(dn[n]);
      nv += int'(mv[n]);
      checks++;
      if (bz[n] !== (n <= 146)) begin
        errors++;
        $display("FAIL full_busy n=%0d got %b", n, bz[n]);
      end
    end
    checks++;
    if (dn[146] !== 1'b1 || nd != 1) begin
      errors++;
      $display("FAIL full_done got dn146=%b count=%0d exp 1,1",
               dn[146], nd);
    end
    checks++;
    if (nv != 144) begin
      errors++;
      $display("FAIL full_valid_count got %0d exp 144", nv);
    end
  endtask

  task automatic test_padding();
    int e00 [9] = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
    int a00 [9] = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
    int a11 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    run(0, -1, 0, 150, -1, -1);
    for (int t = 0; t < 9; t++) begin
      checks++;
      if (en[t+1] !== e00[t][0] || ad[t+1] !== 9'(a00[t]) ||
          mp[t+2] !== !e00[t][0]) begin
        errors++;
        $display("FAIL pad_p00 tap=%0d got en=%b ad=%0d pad=%b exp en=%0d ad=%0d",
                 t, en[t+1], ad[t+1], mp[t+2], e00[t], a00[t]);
      end
      checks++;
      if (en[t+46] !== 1'b1 || ad[t+46] !== 9'(a11[t]) ||
          mp[t+47] !== 1'b0) begin
        errors++;
        $display("FAIL pad_p11 tap=%0d got en=%b ad=%0d exp ad=%0d",
                 t, en[t+46], ad[t+46], a11[t]);
      end
    end
  endtask

  task automatic test_stall();
    int bub;
    bub = 0;
    run(0, 103, 5, 170, -1, -1);
    for (int n = 104; n <= 108; n++) begin
      checks++;
      if (en[n] !== 1'b0 || ad[n] !== 9'd10) begin
        errors++;
        $display("FAIL stall_hold n=%0d got en=%b ad=%0d exp 0,10",
                 n, en[n], ad[n]);
      end
    end
    checks++;
    if (en[109] !== 1'b1 || ad[109] !== 9'd11) begin
      errors++;
      $display("FAIL stall_resume got en=%b ad=%0d exp 1,11",
               en[109], ad[109]);
    end
    checks++;
    if (rw[106] !== 2'd2 || cl[106] !== 2'd3) begin
      errors++;
      $display("FAIL stall_rowcol got %0d,%0d exp 2,3",
               rw[106], cl[106]);
    end
    for (int n = 2; n <= 150; n++) begin
      if (mv[n] === 1'b0) bub++;
    end
    checks++;
    if (bub != 5 || mv[104] !== 1'b1 || mv[110] !== 1'b1 ||
        mt[110] !== 4'd4) begin
      errors++;
      $display("FAIL stall_bubbles got %0d mv104=%b mv110=%b t=%0d exp 5,1,1,4",
               bub, mv[104], mv[110], mt[110]);
    end
    checks++;
    if (dn[151] !== 1'b1 || dn[146] !== 1'b0) begin
      errors++;
      $display("FAIL stall_done got dn151=%b dn146=%b exp 1,0",
               dn[151], dn[146]);
    end
  endtask

  task automatic test_rd_lat3();
    bit e;
    int a, nf, nl;
    nf = 0;
    nl = 0;
    run(1, -1, 0, 160, -1, -1);
    for (int n = 1; n <= 144; n++) begin
      geo(n - 1, e, a);
      checks++;
      if (en[n] !== e || ad[n] !== 9'(a) || mv[n+3] !== 1'b1 ||
          mt[n+3] !== 4'((n - 1) % 9) || mp[n+3] !== !e ||
          mf[n+3] !== ((n - 1) % 9 == 0) ||
          ml[n+3] !== ((n - 1) % 9 == 8)) begin
        errors++;
        $display("FAIL lat3 n=%0d got en=%b ad=%0d v=%b t=%0d p=%b",
                 n, en[n], ad[n], mv[n+3], mt[n+3], mp[n+3]);
      end
    end
    checks++;
    if (mv[1] !== 1'b0 || mv[2] !== 1'b0 || mv[3] !== 1'b0) begin
      errors++;
      $display("FAIL lat3_lead got %b%b%b exp 000", mv[1], mv[2], mv[3]);
    end
    for (int n = 0; n <= 160; n++) begin
      nf += int'(mf[n]);
      nl += int'(ml[n]);
    end
    checks++;
    if (nf != 16 || nl != 16) begin
      errors++;
      $display("FAIL lat3_counts got first=%0d last=%0d exp 16,16",
               nf, nl);
    end
    checks++;
    if (dn[148] !== 1'b1 || dn[147] !== 1'b0) begin
      errors++;
      $display("FAIL lat3_done got dn148=%b dn147=%b exp 1,0",
               dn[148], dn[147]);
    end
  endtask

  task automatic test_back_to_back();
    bit e;
    int a, nd;
    nd = 0;
    run(0, -1, 0, 170, 50, 146);
    for (int n = 1; n <= 144; n++) begin
      geo(n - 1, e, a);
      checks++;
      if (en[n] !== e || ad[n] !== 9'(a)) begin
        errors++;
        $display("FAIL b2b_addr n=%0d got en=%b ad=%0d exp en=%b ad=%0d",
                 n, en[n], ad[n], e, a);
      end
    end
    for (int n = 0; n <= 170; n++) nd += int'(dn[n]);
    checks++;
    if (nd != 1 || dn[146] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got count=%0d dn146=%b exp 1,1",
               nd, dn[146]);
    end
    for (int n = 147; n <= 170; n++) begin
      checks++;
      if (bz[n] !== 1'b0 || en[n] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_idle n=%0d got busy=%b en=%b exp 0,0",
                 n, bz[n], en[n]);
      end
    end
    run(0, -1, 0, 150, -1, -1);
    checks++;
    if (en[1] !== 1'b0 || en[5] !== 1'b1 || ad[5] !== 9'd0 ||
        ad[54] !== 9'd10) begin
      errors++;
      $display("FAIL b2b_restart got en1=%b en5=%b ad5=%0d ad54=%0d",
               en[1], en[5], ad[5], ad[54]);
    end
    checks++;
    if (dn[146] !== 1'b1 || rw[1] !== 2'd0 || cl[1] !== 2'd0) begin
      errors++;
      $display("FAIL b2b_second got dn146=%b row=%0d col=%0d exp 1,0,0",
               dn[146], rw[1], cl[1]);
    end
  endtask

  task automatic test_mid_reset();
    bit e;
    int a, nv;
    nv = 0;
    run(0, -1, 0, 70, -1, -1);
    checks++;
    if (bz[70] !== 1'b1 || rw[70] !== 2'd1 || cl[70] !== 2'd3) begin
      errors++;
      $display("FAIL mrst_pre got busy=%b row=%0d col=%0d exp 1,1,3",
               bz[70], rw[70], cl[70]);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({d1_busy, d1_done, d1_en, d1_ad, d1_mv, d1_mf, d1_ml,
         d1_mp, d1_mt, d1_row, d1_col} !== '0) begin
      errors++;
      $display("FAIL mrst_async got busy=%b en=%b ad=%0d row=%0d col=%0d",
               d1_busy, d1_en, d1_ad, d1_row, d1_col);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (d1_done !== 1'b0 || d1_busy !== 1'b0) begin
        errors++;
        $display("FAIL mrst_hold got done=%b busy=%b exp 0,0",
                 d1_done, d1_busy);
      end
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (d1_done !== 1'b0 || d1_busy !== 1'b0) begin
      errors++;
      $display("FAIL mrst_release got done=%b busy=%b exp 0,0",
               d1_done, d1_busy);
    end
    run(0, -1, 0, 150, -1, -1);
    for (int n = 1; n <= 144; n++) begin
      geo(n - 1, e, a);
      checks++;
      if (en[n] !== e || ad[n] !== 9'(a)) begin
        errors++;
        $display("FAIL mrst_addr n=%0d got en=%b ad=%0d exp en=%b ad=%0d",
                 n, en[n], ad[n], e, a);
      end
    end
    for (int n = 0; n <= 150; n++) nv += int'(mv[n]);
    checks++;
    if (nv != 144 || dn[146] !== 1'b1) begin
      errors++;
      $display("FAIL mrst_rerun got valid=%0d dn146=%b exp 144,1",
               nv, dn[146]);
    end
  endtask

  initial begin
    test_reset();
    test_full();
    test_padding();
    test_stall();
    test_rd_lat3();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
